// File: rtl/reg_status_table.sv
// ---------------------------------------------------------------------------
// reg_status_table
//
// Register status table for the dispatch stage of the Tomasulo pipeline.
// For every architectural register x1..x31 it records whether a result is
// still outstanding and which rename tag will produce it. Register x0 is
// hard-wired: never busy, tag always 0.
//
// Ports
//   i_clk         clock, all state updates on the rising edge
//   i_rst         synchronous active-high reset, highest priority
//   flush         clears every pending entry at the next edge; dispatch and
//                 CDB inputs in the same cycle are ignored
//   disp_wr_en    dispatching an instruction that writes disp_rd_addr
//   disp_rd_addr  destination register of the dispatching instruction
//   disp_tag      rename tag allocated to that instruction
//   cdb_valid     CDB broadcast valid
//   cdb_tag       tag being broadcast on the CDB
//   rs1_addr/rs2_addr   source lookup addresses
//   rs1_busy/rs2_busy   1 = operand pending, 0 = read the register file
//   rs1_tag/rs2_tag     producing tag when busy, 0 otherwise
//   busy_cnt      number of registers currently pending (0..31)
//
// Handshake semantics: disp_wr_en and cdb_valid are pure valid qualifiers
// with no ready/back-pressure path. Each is consumed at the rising edge on
// which it is high (unless i_rst or flush is also high); the dispatch unit
// guarantees disp_wr_en is only raised when a tag is actually available.
// ---------------------------------------------------------------------------
module reg_status_table #(
    parameter int TAG_WIDTH = 6,
    parameter int NUM_REGS  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 flush,
    input  logic                 disp_wr_en,
    input  logic [4:0]           disp_rd_addr,
    input  logic [TAG_WIDTH-1:0] disp_tag,
    input  logic                 cdb_valid,
    input  logic [TAG_WIDTH-1:0] cdb_tag,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [TAG_WIDTH-1:0] rs1_tag,
    output logic [TAG_WIDTH-1:0] rs2_tag,
    output logic [5:0]           busy_cnt
);

    // Entry 0 exists only so the arrays can be indexed directly by a 5-bit
    // address; it is never written and stays 0.
    logic [NUM_REGS-1:0]  busy_q;
    logic [TAG_WIDTH-1:0] tag_q [NUM_REGS];
    logic [5:0]           cnt_q;

    logic [NUM_REGS-1:0]  disp_sel;   // one-hot: entry being dispatched
    logic [NUM_REGS-1:0]  cdb_sel;    // entry whose pending tag is broadcast
    logic                 cnt_inc;
    logic                 cnt_dec;

    // -----------------------------------------------------------------------
    // Per-entry update selects
    // -----------------------------------------------------------------------
    always_comb begin
        disp_sel = '0;
        cdb_sel  = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            disp_sel[r] = disp_wr_en && (disp_rd_addr == 5'(r));
            cdb_sel[r]  = cdb_valid && busy_q[r] && (tag_q[r] == cdb_tag);
        end
    end

    // A dispatch only adds to the count when the entry was idle. A CDB
    // release only subtracts when the same entry is not being redispatched
    // in that cycle, because dispatch wins and the entry stays busy.
    always_comb begin
        cnt_inc = |(disp_sel & ~busy_q);
        cnt_dec = |(cdb_sel & ~disp_sel);
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                tag_q[r] <= '0;
            end
        end else if (flush) begin
            // Tags are left stale; outputs mask them while not busy.
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (disp_sel[r]) begin
                    busy_q[r] <= 1'b1;
                    tag_q[r]  <= disp_tag;
                end else if (cdb_sel[r]) begin
                    busy_q[r] <= 1'b0;
                end
            end
            cnt_q <= cnt_q + {5'd0, cnt_inc} - {5'd0, cnt_dec};
        end
    end

    assign busy_cnt = cnt_q;

    // -----------------------------------------------------------------------
    // Source lookups. A matching CDB broadcast in the same cycle makes the
    // operand ready immediately; a same-cycle dispatch is not forwarded.
    // -----------------------------------------------------------------------
    always_comb begin
        rs1_busy = (rs1_addr != 5'd0) && busy_q[rs1_addr] &&
                   !(cdb_valid && (tag_q[rs1_addr] == cdb_tag));
        rs2_busy = (rs2_addr != 5'd0) && busy_q[rs2_addr] &&
                   !(cdb_valid && (tag_q[rs2_addr] == cdb_tag));
        rs1_tag  = rs1_busy ? tag_q[rs1_addr] : '0;
        rs2_tag  = rs2_busy ? tag_q[rs2_addr] : '0;
    end

    // The running counter must always equal the number of busy entries,
    // and x0 must never become busy.
    a_cnt_matches_busy: assert property (@(posedge i_clk) disable iff (i_rst)
        busy_cnt == 6'($countones(busy_q)));
    a_x0_never_busy: assert property (@(posedge i_clk) disable iff (i_rst)
        busy_q[0] == 1'b0);

endmodule

// File: tb/tb_reg_status_table.sv
module tb_reg_status_table;

    localparam int TW = 6;
    localparam int W  = 20;  // {b1, t1, b2, t2, cnt}

    logic          i_clk;
    logic          i_rst;
    logic          flush;
    logic          disp_wr_en;
    logic [4:0]    disp_rd_addr;
    logic [TW-1:0] disp_tag;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [4:0]    rs1_addr;
    logic [4:0]    rs2_addr;
    logic          rs1_busy;
    logic          rs2_busy;
    logic [TW-1:0] rs1_tag;
    logic [TW-1:0] rs2_tag;
    logic [5:0]    busy_cnt;

    int n_checks = 0;
    int n_err    = 0;

    logic [W-1:0] exp_q[$];

    reg_status_table #(.TAG_WIDTH(TW), .NUM_REGS(32)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .flush        (flush),
        .disp_wr_en   (disp_wr_en),
        .disp_rd_addr (disp_rd_addr),
        .disp_tag     (disp_tag),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rs1_tag      (rs1_tag),
        .rs2_tag      (rs2_tag),
        .busy_cnt     (busy_cnt)
    );

    // ---------------- clock / reset ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // ---------------- vector table ----------------
    // Expected outputs are the values seen in the same cycle, before the
    // edge that commits that row's inputs.
    typedef struct {
        logic          wr;
        logic [4:0]    rd;
        logic [TW-1:0] dtag;
        logic          cv;
        logic [TW-1:0] ctag;
        logic [4:0]    a1;
        logic [4:0]    a2;
        logic          eb1;
        logic [TW-1:0] et1;
        logic          eb2;
        logic [TW-1:0] et2;
        logic [5:0]    ecnt;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst, input logic fl, input logic wr,
                         input logic [4:0] rd, input logic [TW-1:0] dtag,
                         input logic cv, input logic [TW-1:0] ctag,
                         input logic [4:0] a1, input logic [4:0] a2);
        i_rst        = rst;
        flush        = fl;
        disp_wr_en   = wr;
        disp_rd_addr = rd;
        disp_tag     = dtag;
        cdb_valid    = cv;
        cdb_tag      = ctag;
        rs1_addr     = a1;
        rs2_addr     = a2;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic check_outs(input string name, input logic eb1, input logic [TW-1:0] et1,
                              input logic eb2, input logic [TW-1:0] et2,
                              input logic [5:0] ecnt);
        exp_q.push_back({eb1, et1, eb2, et2, ecnt});
        compare_front(name);
    endtask

    // ---------------- scoreboard ----------------
    task automatic compare_front(input string name);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check({name, ".rs1_busy"}, int'(rs1_busy), int'(e[19]));
            check({name, ".rs1_tag"},  int'(rs1_tag),  int'(e[18:13]));
            check({name, ".rs2_busy"}, int'(rs2_busy), int'(e[12]));
            check({name, ".rs2_tag"},  int'(rs2_tag),  int'(e[11:6]));
            check({name, ".busy_cnt"}, int'(busy_cnt), int'(e[5:0]));
        end
    endtask

    // ---------------- reference model for the random stream ----------------
    logic          m_busy [32];
    logic [TW-1:0] m_tag  [32];

    function automatic int m_count();
        int c = 0;
        for (int r = 0; r < 32; r++) if (m_busy[r]) c++;
        return c;
    endfunction

    function automatic logic tag_held(input logic [TW-1:0] t);
        for (int r = 1; r < 32; r++) if (m_busy[r] && m_tag[r] == t) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- test ----------------
    initial begin
        // wr rd dtag cv ctag a1 a2 | eb1 et1 eb2 et2 cnt
        vecs[0]  = '{1'b0, 5'd0, 6'd0,  1'b0, 6'd0,  5'd5, 5'd0, 1'b0, 6'd0,  1'b0, 6'd0,  6'd0};
        vecs[1]  = '{1'b1, 5'd5, 6'd12, 1'b0, 6'd0,  5'd5, 5'd0, 1'b0, 6'd0,  1'b0, 6'd0,  6'd0};
        vecs[2]  = '{1'b0, 5'd0, 6'd0,  1'b0, 6'd0,  5'd5, 5'd0, 1'b1, 6'd12, 1'b0, 6'd0,  6'd1};
        vecs[3]  = '{1'b0, 5'd0, 6'd0,  1'b1, 6'd12, 5'd5, 5'd0, 1'b0, 6'd0,  1'b0, 6'd0,  6'd1};
        vecs[4]  = '{1'b0, 5'd0, 6'd0,  1'b0, 6'd0,  5'd5, 5'd0, 1'b0, 6'd0,  1'b0, 6'd0,  6'd0};
        vecs[5]  = '{1'b1, 5'd5, 6'd12, 1'b0, 6'd0,  5'd5, 5'd0, 1'b0, 6'd0,  1'b0, 6'd0,  6'd0};
        vecs[6]  = '{1'b1, 5'd5, 6'd20, 1'b0, 6'd0,  5'd5, 5'd0, 1'b1, 6'd12, 1'b0, 6'd0,  6'd1};
        vecs[7]  = '{1'b0, 5'd0, 6'd0,  1'b1, 6'd12, 5'd5, 5'd0, 1'b1, 6'd20, 1'b0, 6'd0,  6'd1};
        vecs[8]  = '{1'b0, 5'd0, 6'd0,  1'b1, 6'd20, 5'd5, 5'd5, 1'b0, 6'd0,  1'b0, 6'd0,  6'd1};
        vecs[9]  = '{1'b0, 5'd0, 6'd0,  1'b0, 6'd0,  5'd5, 5'd0, 1'b0, 6'd0,  1'b0, 6'd0,  6'd0};
        vecs[10] = '{1'b1, 5'd7, 6'd9,  1'b0, 6'd0,  5'd7, 5'd0, 1'b0, 6'd0,  1'b0, 6'd0,  6'd0};
        vecs[11] = '{1'b1, 5'd7, 6'd3,  1'b1, 6'd9,  5'd7, 5'd0, 1'b0, 6'd0,  1'b0, 6'd0,  6'd1};
        vecs[12] = '{1'b0, 5'd0, 6'd0,  1'b0, 6'd0,  5'd7, 5'd0, 1'b1, 6'd3,  1'b0, 6'd0,  6'd1};
        vecs[13] = '{1'b1, 5'd0, 6'd40, 1'b0, 6'd0,  5'd0, 5'd7, 1'b0, 6'd0,  1'b1, 6'd3,  6'd1};
        vecs[14] = '{1'b0, 5'd0, 6'd0,  1'b0, 6'd0,  5'd0, 5'd7, 1'b0, 6'd0,  1'b1, 6'd3,  6'd1};
        vecs[15] = '{1'b1, 5'd7, 6'd3,  1'b1, 6'd3,  5'd7, 5'd0, 1'b0, 6'd0,  1'b0, 6'd0,  6'd1};
        vecs[16] = '{1'b0, 5'd0, 6'd0,  1'b0, 6'd0,  5'd7, 5'd0, 1'b1, 6'd3,  1'b0, 6'd0,  6'd1};
        vecs[17] = '{1'b1, 5'd8, 6'd30, 1'b1, 6'd3,  5'd7, 5'd8, 1'b0, 6'd0,  1'b0, 6'd0,  6'd1};
        vecs[18] = '{1'b0, 5'd0, 6'd0,  1'b0, 6'd0,  5'd7, 5'd8, 1'b0, 6'd0,  1'b1, 6'd30, 6'd1};
        vecs[19] = '{1'b0, 5'd0, 6'd0,  1'b1, 6'd30, 5'd0, 5'd8, 1'b0, 6'd0,  1'b0, 6'd0,  6'd1};
        vecs[20] = '{1'b0, 5'd0, 6'd0,  1'b0, 6'd0,  5'd0, 5'd8, 1'b0, 6'd0,  1'b0, 6'd0,  6'd0};

        drive(1'b1, 1'b0, 1'b0, 5'd0, '0, 1'b0, '0, 5'd0, 5'd0);
        next_cycle();
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, '0, 1'b0, '0, 5'd0, 5'd0);

        // Directed table
        for (int i = 0; i < NV; i++) begin
            drive(1'b0, 1'b0, vecs[i].wr, vecs[i].rd, vecs[i].dtag,
                  vecs[i].cv, vecs[i].ctag, vecs[i].a1, vecs[i].a2);
            @(negedge i_clk);
            check_outs($sformatf("vec%0d", i), vecs[i].eb1, vecs[i].et1,
                       vecs[i].eb2, vecs[i].et2, vecs[i].ecnt);
            next_cycle();
        end

        // Fill x1..x31 with tags 1..31
        for (int r = 1; r < 32; r++) begin
            drive(1'b0, 1'b0, 1'b1, 5'(r), 6'(r), 1'b0, '0, 5'd0, 5'd0);
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, '0, 1'b0, '0, 5'd1, 5'd31);
        @(negedge i_clk);
        check_outs("fill", 1'b1, 6'd1, 1'b1, 6'd31, 6'd31);
        next_cycle();

        // Flush with a dispatch and CDB in the same cycle: pre-edge view kept
        drive(1'b0, 1'b1, 1'b1, 5'd4, 6'd50, 1'b1, 6'd10, 5'd10, 5'd31);
        @(negedge i_clk);
        check_outs("flush_cycle", 1'b0, 6'd0, 1'b1, 6'd31, 6'd31);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, '0, 1'b0, '0, 5'd4, 5'd0);
        for (int r = 1; r < 32; r++) begin
            rs1_addr = 5'(r);
            rs2_addr = 5'(32 - r);
            #1;
            check_outs($sformatf("after_flush_r%0d", r), 1'b0, 6'd0, 1'b0, 6'd0, 6'd0);
        end
        next_cycle();

        // Reset mid-operation with a pending dispatch
        drive(1'b0, 1'b0, 1'b1, 5'd3, 6'd7, 1'b0, '0, 5'd3, 5'd0);
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, 5'd9, 6'd8, 1'b0, '0, 5'd3, 5'd9);
        @(negedge i_clk);
        check_outs("rst_cycle", 1'b1, 6'd7, 1'b0, 6'd0, 6'd1);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, '0, 1'b0, '0, 5'd3, 5'd9);
        @(negedge i_clk);
        check_outs("after_rst", 1'b0, 6'd0, 1'b0, 6'd0, 6'd0);
        next_cycle();

        // Random stream against the reference model (state is fully reset here)
        for (int r = 0; r < 32; r++) begin
            m_busy[r] = 1'b0;
            m_tag[r]  = '0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic          rst_v, fl_v, wr_v, cv_v;
            logic [4:0]    rd_v, a1_v, a2_v;
            logic [TW-1:0] dt_v, ct_v;
            logic          eb1, eb2;
            logic [TW-1:0] et1, et2;
            int            start;

            rst_v = (cyc == 5000);
            fl_v  = ($urandom_range(0, 199) == 0);
            wr_v  = ($urandom_range(0, 99) < 60);
            rd_v  = 5'($urandom_range(0, 31));
            dt_v  = 6'($urandom_range(0, 63));
            for (int k = 0; k < 64 && tag_held(dt_v); k++) dt_v = dt_v + 6'd1;
            cv_v  = ($urandom_range(0, 99) < 50);
            ct_v  = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 99) < 75) begin
                start = $urandom_range(1, 31);
                for (int k = 0; k < 31; k++) begin
                    int r = ((start - 1 + k) % 31) + 1;
                    if (m_busy[r]) begin
                        ct_v = m_tag[r];
                        break;
                    end
                end
            end
            a1_v = 5'($urandom_range(0, 31));
            a2_v = 5'($urandom_range(0, 31));

            drive(rst_v, fl_v, wr_v, rd_v, dt_v, cv_v, ct_v, a1_v, a2_v);

            eb1 = (a1_v != 0) && m_busy[a1_v] && !(cv_v && m_tag[a1_v] == ct_v);
            eb2 = (a2_v != 0) && m_busy[a2_v] && !(cv_v && m_tag[a2_v] == ct_v);
            et1 = eb1 ? m_tag[a1_v] : '0;
            et2 = eb2 ? m_tag[a2_v] : '0;
            exp_q.push_back({eb1, et1, eb2, et2, 6'(m_count())});

            @(negedge i_clk);
            compare_front($sformatf("rand%0d", cyc));

            if (rst_v) begin
                for (int r = 0; r < 32; r++) begin
                    m_busy[r] = 1'b0;
                    m_tag[r]  = '0;
                end
            end else if (fl_v) begin
                for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
            end else begin
                if (cv_v) begin
                    for (int r = 1; r < 32; r++)
                        if (m_busy[r] && m_tag[r] == ct_v) m_busy[r] = 1'b0;
                end
                if (wr_v && rd_v != 0) begin
                    m_busy[rd_v] = 1'b1;
                    m_tag[rd_v]  = dt_v;
                end
            end
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_status_table.md
# reg_status_table

Register status table for the dispatch stage of the RISC-V Tomasulo pipeline. It tracks, per architectural register, whether a result is still pending and which 6-bit tag will produce it. It consumes tags handed out by the tag FIFO at dispatch and releases them when the matching tag is broadcast on the CDB. Source lookups from the dispatch unit return ready/tag pairs to the reservation stations.

## Interface
- TAG_WIDTH, 6, width of a rename tag; must equal the tag FIFO data width
- NUM_REGS, 32, architectural registers; x0 is hard-wired and never tracked
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-high
- flush  in  1  pipeline flush; clears all pending state at the next edge
- disp_wr_en  in  1  dispatching an instruction that writes rd; asserted together with the tag FIFO read enable
- disp_rd_addr  in  5  destination register of the dispatching instruction
- disp_tag  in  TAG_WIDTH  tag allocated to it (tag FIFO output)
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_WIDTH  tag being broadcast
- rs1_addr, rs2_addr  in  5 each  source lookup addresses
- rs1_busy, rs2_busy  out  1 each  1 = operand pending; 0 = read from register file
- rs1_tag, rs2_tag  out  TAG_WIDTH each  producing tag when busy; 0 when not busy
- busy_cnt  out  6  number of registers currently pending (0..31)

## Operation
- State: per register r in 1..31, busy[r] (1 bit) and tag[r] (TAG_WIDTH). Register 0: busy is always 0, tag is always 0. Writes to register 0 are ignored.
- Dispatch: when disp_wr_en and disp_rd_addr != 0, set busy[rd]=1 and tag[rd]=disp_tag at the next edge. Overwriting an already-busy register replaces its tag. No busy_cnt increment in that case.
- CDB release: when cdb_valid, every entry with busy=1 and tag==cdb_tag clears busy at the next edge. Tags are unique, so at most one entry matches. The stale tag value may remain, but the output tag is forced to 0 when not busy.
- Simultaneous dispatch and CDB on the same rd: dispatch wins, and the entry ends busy with disp_tag. This holds even when cdb_tag equals the old tag or equals disp_tag.
- Simultaneous dispatch and CDB on different registers: both take effect.
- busy_cnt:
  - next = current + (dispatch sets a previously non-busy entry) − (CDB clears an entry that is not also being redispatched).
  - The counter is always equal to the popcount of busy. It never wraps; a mismatch is a design error, flagged by an assertion.
- Lookups:
  - Combinational from current state, with CDB bypass: if cdb_valid and cdb_tag equals the entry tag of a busy source, report busy=0 and tag=0 in the same cycle.
  - No bypass from the same-cycle disp_wr_en. Intra-bundle dependences are the dispatch unit's responsibility.
  - Address 0 always reports busy=0, tag=0.
- Flush: all busy cleared and busy_cnt=0 at the next edge. Dispatch and CDB inputs in the flush cycle are ignored. The tag FIFO resets its own pointers on the same flush.
- Reset: i_rst has priority over flush and all other inputs.

## Timing
- Reset (i_rst high at an edge): all busy=0, all tags=0, busy_cnt=0. Consequently rs1_busy=rs2_busy=0, rs1_tag=rs2_tag=0.
- Dispatch-to-visible latency: 1 cycle. Dispatch at edge N means a lookup in cycle N+1 returns busy=1 with the new tag.
- CDB-to-ready latency: 0 cycles via the bypass. State is cleared at the following edge.
- Reset or flush asserted mid-operation: state is cleared on that edge regardless of pending dispatch or CDB inputs. Lookups in the reset/flush cycle still reflect pre-edge state.
- No handshake back-pressure. The dispatch unit must not assert disp_wr_en while the tag FIFO reports empty.

## Test plan
- Reset then lookup of rs1=5, rs2=0 → busy=0, tag=0, busy_cnt=0.
- Dispatch rd=5, tag=12; next cycle lookup rs1=5 → busy=1, tag=12, busy_cnt=1. Then CDB tag=12 → same-cycle rs1_busy=0; next cycle busy_cnt=0.
- Dispatch rd=5 tag=12, then rd=5 tag=20; CDB tag=12 → rs1=5 stays busy with tag 20, busy_cnt=1. CDB tag=20 → cleared, busy_cnt=0.
- Same edge: dispatch rd=7 tag=3 while CDB tag=9 (old tag of r7) → r7 busy, tag 3, busy_cnt unchanged. Dispatch rd=0 → no change, busy_cnt unchanged.
- Fill r1..r31 with tags 1..31 → busy_cnt=31. Assert flush together with dispatch rd=4 → next cycle all busy=0, busy_cnt=0.
- Random dispatch/CDB stream of 10k cycles against a reference model → lookups match every cycle and busy_cnt equals popcount(busy). Include an i_rst pulse mid-stream, after which all outputs return to reset values.
